// File: rtl/cmp_pipe_if.sv
// Request/result bus of the pipelined branch comparator.
// Request side: in_valid/in_ready handshake carrying cmpop, a, b, tag; flush
// kills everything in flight. Result side: out_valid/out_ready handshake
// carrying br_en, eq, lt, illegal, out_tag.
// master: the core issuing compares; slave: cmp_pipe.
interface cmp_pipe_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       cmpop;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [TAG_W-1:0] tag;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic             br_en;
   logic             eq;
   logic             lt;
   logic             illegal;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, cmpop, a, b, tag, flush, out_ready,
      input  in_ready, out_valid, br_en, eq, lt, illegal, out_tag
   );

   modport slave (
      input  in_valid, cmpop, a, b, tag, flush, out_ready,
      output in_ready, out_valid, br_en, eq, lt, illegal, out_tag
   );
endinterface

// File: rtl/cmp_pipe.sv
// Pipelined RISC-V branch comparator with fixed latency STAGES.
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          cmp_pipe_if.slave request/result handshake bus
//   clr_cnt      synchronous clear of both performance counters
//   cnt_resolved saturating count of handed-off results
//   cnt_taken    saturating count of handed-off results with br_en=1
// The compare is evaluated combinationally on the request and captured into
// stage 1; stages 1..STAGES form an elastic shift pipeline and the outputs are
// driven straight from the last stage.
module cmp_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 5,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   cmp_pipe_if.slave        bus,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] cnt_resolved,
   output logic [CNT_W-1:0] cnt_taken
);

   typedef struct packed {
      logic             br_en;
      logic             eq;
      logic             lt;
      logic             illegal;
      logic [TAG_W-1:0] tag;
   } res_t;

   res_t              res_in;
   res_t              res_src [0:STAGES-1];
   res_t              res_q   [1:STAGES];
   logic [STAGES:1]   vld;
   logic [STAGES:1]   rdy;
   logic [STAGES-1:0] vld_src;
   logic              all_full;
   logic              handoff;

   always_comb begin
      res_in         = '0;
      res_in.tag     = bus.tag;
      res_in.eq      = (bus.a == bus.b);
      res_in.lt      = bus.cmpop[1] ? (bus.a < bus.b)
                                    : ($signed(bus.a) < $signed(bus.b));
      res_in.illegal = (bus.cmpop[2:1] == 2'b01);
      case (bus.cmpop)
         3'b000:         res_in.br_en = res_in.eq;
         3'b001:         res_in.br_en = !res_in.eq;
         3'b100, 3'b110: res_in.br_en = res_in.lt;
         3'b101, 3'b111: res_in.br_en = !res_in.lt;
         default:        res_in.br_en = 1'b0;
      endcase
   end

   // Stage k can take new data when the consumer accepts or some stage at or
   // after k is empty; written as a suffix AND to avoid a combinational
   // self-loop through the rdy vector.
   always_comb begin
      rdy      = '0;
      all_full = 1'b1;
      for (int k = STAGES; k >= 1; k--) begin
         all_full = all_full & vld[k];
         rdy[k]   = bus.out_ready | ~all_full;
      end
   end

   always_comb begin
      vld_src    = '0;
      vld_src[0] = bus.in_valid;
      res_src[0] = res_in;
      for (int k = 1; k < STAGES; k++) begin
         vld_src[k] = vld[k];
         res_src[k] = res_q[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int k = 1; k <= STAGES; k++) begin
            res_q[k] <= '0;
         end
      end else begin
         for (int k = 1; k <= STAGES; k++) begin
            if (bus.flush) begin
               vld[k] <= 1'b0;
            end else if (rdy[k]) begin
               vld[k] <= vld_src[k-1];
            end
            if (rdy[k]) begin
               res_q[k] <= res_src[k-1];
            end
         end
      end
   end

   assign bus.in_ready  = rdy[1];
   assign bus.out_valid = vld[STAGES];
   assign bus.br_en     = res_q[STAGES].br_en;
   assign bus.eq        = res_q[STAGES].eq;
   assign bus.lt        = res_q[STAGES].lt;
   assign bus.illegal   = res_q[STAGES].illegal;
   assign bus.out_tag   = res_q[STAGES].tag;

   // A result presented during a flush is discarded, so it is not counted.
   assign handoff = bus.out_valid && bus.out_ready && !bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_resolved <= '0;
         cnt_taken    <= '0;
      end else if (clr_cnt) begin
         cnt_resolved <= '0;
         cnt_taken    <= '0;
      end else if (handoff) begin
         if (cnt_resolved != '1) begin
            cnt_resolved <= cnt_resolved + CNT_W'(1);
         end
         if (bus.br_en && (cnt_taken != '1)) begin
            cnt_taken <= cnt_taken + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/cmp_pipe.md
Name: cmp_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle branch comparator in the execute stage.
- Takes a RISC-V branch funct3 and two WIDTH-bit operands under a valid/ready handshake and returns br_en, eq and lt flags after STAGES cycles.
- Carries a TAG_W-bit tag alongside each result so the core can match results to branches.
- Supports pipeline flush, flags illegal ops, and keeps saturating resolved/taken performance counters.

Parameters:
WIDTH, 32, operand width in bits (>=2)
STAGES, 2, pipeline depth and fixed latency in cycles (1..4)
TAG_W, 5, width of tag carried with each request
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request this cycle
cmpop  in  3  branch funct3: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu; 010/011 illegal
a  in  WIDTH  operand rs1
b  in  WIDTH  operand rs2
tag  in  TAG_W  request tag
flush  in  1  kill all in-flight and same-cycle requests
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
br_en  out  1  branch taken
eq  out  1  a == b
lt  out  1  a < b; signed for cmpop[1]=0, unsigned for cmpop[1]=1
illegal  out  1  request carried an illegal cmpop
out_tag  out  TAG_W  tag of result
clr_cnt  in  1  synchronous counter clear
cnt_resolved  out  CNT_W  results handed off
cnt_taken  out  CNT_W  handed-off results with br_en=1

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0, out_valid=0, br_en/eq/lt/illegal=0, out_tag=0, both counters 0. in_ready=1 once reset is released.
- Compare is computed combinationally from the input and captured into stage 1. Stages 1..STAGES form an elastic shift pipeline, each with a valid bit. Outputs are driven from stage STAGES.
- Arithmetic:
  - eq = (a==b).
  - Signed lt uses two's complement of WIDTH bits; unsigned lt uses a plain magnitude compare.
  - br_en: beq eq; bne !eq; blt/bltu lt; bge/bgeu !lt.
- Illegal cmpop: illegal=1, br_en=0, eq/lt still computed. The result is never X.
- Handshakes:
  - Request is accepted when in_valid && in_ready.
  - Result is handed off when out_valid && out_ready.
  - Stage k advances when stage k+1 is empty or advancing. The last stage advances on out_ready.
  - in_ready = !valid[1] || stage 1 advances. Back-to-back throughput is 1 per cycle.
- Latency: a request accepted in cycle t presents out_valid in cycle t+STAGES when there is no backpressure.
- Stall: while out_valid && !out_ready, all outputs hold stable and no data is lost. The pipeline fills to STAGES entries, then in_ready=0.
- Flush: all valid bits clear at the next edge, and a request presented in the flush cycle is dropped. out_valid may be 1 in the flush cycle, but that result does not count as handed off. in_ready is unaffected.
- Counters:
  - On handoff, cnt_resolved+1; cnt_taken+1 if br_en.
  - Illegal results count in resolved, never in taken.
  - Both counters saturate at all-ones.
  - clr_cnt zeroes both counters and wins over a same-cycle increment.
- rst_n asserted mid-operation discards all in-flight results immediately.

Test Plan:
1. STAGES=2, blt a=0xFFFFFFFF, b=0x00000001, tag=3, out_ready=1 -> two cycles later out_valid=1, br_en=1, lt=1, out_tag=3; cnt_taken=1.
2. bltu with the same operands, then bgeu with the same operands -> br_en=0, then br_en=1. bne a=b=0x1234 -> br_en=0, eq=1.
3. Four back-to-back requests, out_ready=0 for 5 cycles then 1:
   - Outputs stay stable while stalled; in_ready drops after the 2nd accept.
   - All four results emerge in order, tags 0,1,2,3.
   - cnt_resolved=4.
4. Two requests in flight, flush=1 together with a new in_valid -> no out_valid on the following cycles; cnt_resolved unchanged.
5. cmpop=010, a=b=0 -> illegal=1, br_en=0, eq=1; cnt_resolved+1, cnt_taken+0.
6. CNT_W=4:
   - 17 taken handoffs -> both counters hold 0xF.
   - clr_cnt asserted in the same cycle as a handoff -> both read 0.
   - rst_n pulsed low mid-stream -> out_valid=0 immediately.
